// File: rtl/stream_demux_buf.sv
// stream_demux_buf: 1-to-N handshaked stream demultiplexer with a one-entry
// output register per channel and an optional broadcast to every channel.
//
// Ports:
//   clk, rst_n  rising-edge clock, asynchronous active-low reset
//   in_valid    producer has a word
//   in_ready    block accepts the word this cycle (combinational)
//   in_data     input word (W bits)
//   in_sel      target channel for unicast (SEL_W bits)
//   in_bcast    1 = write the word to every channel, in_sel ignored
//   out_valid   per-channel valid, bit k = channel k
//   out_ready   per-channel consumer ready
//   out_data    channel k data at [k*W +: W]
//   sel_err     one-cycle pulse after a word with in_sel >= N was dropped
//   acc_cnt     count of accepted words, wraps modulo 2**CNT_W
module stream_demux_buf #(
    parameter int unsigned W     = 5,
    parameter int unsigned N     = 16,
    parameter int unsigned SEL_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_data,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_bcast,
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ready,
    output logic [N*W-1:0]     out_data,
    output logic               sel_err,
    output logic [CNT_W-1:0]   acc_cnt
);

    logic [N-1:0] free;
    logic [N-1:0] sel_hit;
    logic [N-1:0] load;
    logic         sel_ok;
    logic         accept;

    // One-hot decode of in_sel; an out-of-range select decodes to all zeros.
    always_comb begin
        sel_hit = '0;
        for (int unsigned k = 0; k < N; k++) begin
            sel_hit[k] = (in_sel == SEL_W'(k));
        end
    end

    // A slot is free when empty or being drained this cycle.
    assign free   = ~out_valid | out_ready;
    assign sel_ok = |sel_hit;

    // Out-of-range unicast words are always sunk so the producer never stalls on them.
    always_comb begin
        in_ready = 1'b1;
        if (in_bcast) begin
            in_ready = &free;
        end else if (sel_ok) begin
            in_ready = |(sel_hit & free);
        end
    end

    assign accept = in_valid & in_ready;
    assign load   = accept ? (in_bcast ? {N{1'b1}} : sel_hit) : {N{1'b0}};

    // Per-channel output register; a load takes priority over a drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            for (int unsigned k = 0; k < N; k++) begin
                if (load[k]) begin
                    out_valid[k]         <= 1'b1;
                    out_data[k*W +: W]   <= in_data;
                end else if (out_ready[k]) begin
                    out_valid[k]         <= 1'b0;
                end
            end
        end
    end

    // Dropped-select pulse and accepted-word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
            acc_cnt <= '0;
        end else begin
            sel_err <= accept & ~in_bcast & ~sel_ok;
            if (accept) begin
                acc_cnt <= acc_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_stream_demux_buf.sv
// Directed bench for stream_demux_buf: a default instance (W=5, N=16, CNT_W=16)
// and a narrow instance (N=12, SEL_W=4, CNT_W=4) for bad-select and counter wrap.
module tb_stream_demux_buf;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_data;
    logic [3:0]  in_sel;
    logic        in_bcast;
    logic [15:0] out_valid;
    logic [15:0] out_ready;
    logic [79:0] out_data;
    logic        sel_err;
    logic [15:0] acc_cnt;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [4:0]  b_in_data;
    logic [3:0]  b_in_sel;
    logic        b_in_bcast;
    logic [11:0] b_out_valid;
    logic [11:0] b_out_ready;
    logic [59:0] b_out_data;
    logic        b_sel_err;
    logic [3:0]  b_acc_cnt;

    int n_cmp;
    int n_fail;
    int exp_cnt;

    stream_demux_buf #(.W(5), .N(16), .SEL_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_bcast(in_bcast),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sel_err(sel_err), .acc_cnt(acc_cnt)
    );

    stream_demux_buf #(.W(5), .N(12), .SEL_W(4), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_sel(b_in_sel), .in_bcast(b_in_bcast),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .sel_err(b_sel_err), .acc_cnt(b_acc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 16'h0) begin n_fail++; $display("FAIL reset_out_valid got=%h exp=0000", out_valid); end
        n_cmp++; if (out_data !== 80'h0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (acc_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_acc_cnt got=%0d exp=0", acc_cnt); end
        n_cmp++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL reset_sel_err got=%b exp=0", sel_err); end
        n_cmp++; if (b_out_valid !== 12'h0) begin n_fail++; $display("FAIL reset_b_out_valid got=%h exp=000", b_out_valid); end
        n_cmp++; if (b_acc_cnt !== 4'h0) begin n_fail++; $display("FAIL reset_b_acc_cnt got=%0d exp=0", b_acc_cnt); end
        exp_cnt = 0;
        step();
    endtask

    task automatic test_unicast_sweep();
        for (int s = 0; s < 16; s++) begin
            in_valid = 1'b1; in_bcast = 1'b0; in_data = 5'h0A; in_sel = 4'(s);
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL sweep_in_ready sel=%0d got=%b exp=1", s, in_ready); end
            step();
            exp_cnt++;
            n_cmp++; if (out_valid !== (16'h1 << s)) begin n_fail++; $display("FAIL sweep_out_valid sel=%0d got=%h exp=%h", s, out_valid, 16'h1 << s); end
            n_cmp++; if (out_data[s*5 +: 5] !== 5'h0A) begin n_fail++; $display("FAIL sweep_out_data sel=%0d got=%h exp=0a", s, out_data[s*5 +: 5]); end
        end
        in_valid = 1'b0;
        n_cmp++; if (acc_cnt !== 16'd16) begin n_fail++; $display("FAIL sweep_acc_cnt got=%0d exp=16", acc_cnt); end
        step();
        n_cmp++; if (out_valid !== 16'h0) begin n_fail++; $display("FAIL sweep_drain got=%h exp=0000", out_valid); end
    endtask

    task automatic test_stall();
        out_ready = 16'hFFFF; out_ready[3] = 1'b0;
        in_valid = 1'b1; in_bcast = 1'b0; in_sel = 4'd3; in_data = 5'h0A;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_first_ready got=%b exp=1", in_ready); end
        step(); exp_cnt++;
        n_cmp++; if (out_valid !== 16'h0008 || out_data[15 +: 5] !== 5'h0A) begin n_fail++; $display("FAIL stall_first_load valid=%h data=%h exp=0008/0a", out_valid, out_data[15 +: 5]); end
        // Unicast to another free channel while ch3 stalls.
        in_sel = 4'd5; in_data = 5'h0C;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_other_ready got=%b exp=1", in_ready); end
        step(); exp_cnt++;
        n_cmp++; if (out_valid !== 16'h0028 || out_data[25 +: 5] !== 5'h0C) begin n_fail++; $display("FAIL stall_other_load valid=%h data=%h exp=0028/0c", out_valid, out_data[25 +: 5]); end
        in_sel = 4'd3; in_data = 5'h0B;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_second_ready got=%b exp=0", in_ready); end
        step();
        n_cmp++; if (out_valid !== 16'h0008 || out_data[15 +: 5] !== 5'h0A) begin n_fail++; $display("FAIL stall_hold valid=%h data=%h exp=0008/0a", out_valid, out_data[15 +: 5]); end
        n_cmp++; if (acc_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL stall_hold_cnt got=%0d exp=%0d", acc_cnt, exp_cnt); end
        out_ready[3] = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready got=%b exp=1", in_ready); end
        step(); exp_cnt++;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 16'h0008 || out_data[15 +: 5] !== 5'h0B) begin n_fail++; $display("FAIL stall_second_load valid=%h data=%h exp=0008/0b", out_valid, out_data[15 +: 5]); end
        n_cmp++; if (acc_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL stall_cnt got=%0d exp=%0d", acc_cnt, exp_cnt); end
        step();
        n_cmp++; if (out_valid !== 16'h0) begin n_fail++; $display("FAIL stall_drain got=%h exp=0000", out_valid); end
    endtask

    task automatic test_bcast();
        out_ready = 16'hFFFF; out_ready[7] = 1'b0;
        in_valid = 1'b1; in_bcast = 1'b0; in_sel = 4'd7; in_data = 5'h11;
        step(); exp_cnt++;
        in_bcast = 1'b1; in_data = 5'h15; in_sel = 4'd2;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bcast_blocked_ready got=%b exp=0", in_ready); end
        step();
        n_cmp++; if (out_valid !== 16'h0080 || out_data[35 +: 5] !== 5'h11) begin n_fail++; $display("FAIL bcast_blocked_hold valid=%h data=%h exp=0080/11", out_valid, out_data[35 +: 5]); end
        out_ready[7] = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bcast_release_ready got=%b exp=1", in_ready); end
        step(); exp_cnt++;
        in_valid = 1'b0; in_bcast = 1'b0;
        n_cmp++; if (out_valid !== 16'hFFFF) begin n_fail++; $display("FAIL bcast_out_valid got=%h exp=ffff", out_valid); end
        n_cmp++; if (out_data !== {16{5'h15}}) begin n_fail++; $display("FAIL bcast_out_data got=%h exp=%h", out_data, {16{5'h15}}); end
        n_cmp++; if (acc_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL bcast_cnt got=%0d exp=%0d", acc_cnt, exp_cnt); end
        step();
        n_cmp++; if (out_valid !== 16'h0) begin n_fail++; $display("FAIL bcast_drain got=%h exp=0000", out_valid); end
    endtask

    task automatic test_bad_sel();
        b_in_valid = 1'b1; b_in_bcast = 1'b0; b_in_sel = 4'd13; b_in_data = 5'h1F;
        #1;
        n_cmp++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL badsel_ready got=%b exp=1", b_in_ready); end
        step();
        b_in_valid = 1'b0;
        n_cmp++; if (b_out_valid !== 12'h0) begin n_fail++; $display("FAIL badsel_out_valid got=%h exp=000", b_out_valid); end
        n_cmp++; if (b_sel_err !== 1'b1) begin n_fail++; $display("FAIL badsel_err_pulse got=%b exp=1", b_sel_err); end
        n_cmp++; if (b_acc_cnt !== 4'd1) begin n_fail++; $display("FAIL badsel_cnt got=%0d exp=1", b_acc_cnt); end
        step();
        n_cmp++; if (b_sel_err !== 1'b0) begin n_fail++; $display("FAIL badsel_err_clear got=%b exp=0", b_sel_err); end
        // Highest legal channel still routes normally.
        b_in_valid = 1'b1; b_in_sel = 4'd11; b_in_data = 5'h03;
        step();
        b_in_valid = 1'b0;
        n_cmp++; if (b_out_valid !== 12'h800 || b_out_data[55 +: 5] !== 5'h03 || b_sel_err !== 1'b0) begin n_fail++; $display("FAIL badsel_top_ch valid=%h data=%h err=%b exp=800/03/0", b_out_valid, b_out_data[55 +: 5], b_sel_err); end
        step();
    endtask

    task automatic test_async_reset();
        out_ready = 16'hFFFF; out_ready[2] = 1'b0; out_ready[9] = 1'b0;
        in_valid = 1'b1; in_bcast = 1'b0; in_sel = 4'd2; in_data = 5'h01;
        step();
        in_sel = 4'd9; in_data = 5'h02;
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 16'h0204) begin n_fail++; $display("FAIL areset_pre got=%h exp=0204", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 16'h0) begin n_fail++; $display("FAIL areset_out_valid got=%h exp=0000", out_valid); end
        n_cmp++; if (out_data !== 80'h0) begin n_fail++; $display("FAIL areset_out_data got=%h exp=0", out_data); end
        n_cmp++; if (acc_cnt !== 16'h0) begin n_fail++; $display("FAIL areset_acc_cnt got=%0d exp=0", acc_cnt); end
        #1;
        rst_n = 1'b1;
        out_ready = 16'hFFFF;
        exp_cnt = 0;
        step();
    endtask

    task automatic test_wrap();
        b_in_valid = 1'b1; b_in_bcast = 1'b0; b_in_sel = 4'd0; b_in_data = 5'h07;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 15) begin
                n_cmp++; if (b_acc_cnt !== 4'd15) begin n_fail++; $display("FAIL wrap_max got=%0d exp=15", b_acc_cnt); end
            end
        end
        b_in_valid = 1'b0;
        n_cmp++; if (b_acc_cnt !== 4'd0) begin n_fail++; $display("FAIL wrap_zero got=%0d exp=0", b_acc_cnt); end
        step();
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; exp_cnt = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_sel = '0; in_bcast = 1'b0; out_ready = 16'hFFFF;
        b_in_valid = 1'b0; b_in_data = '0; b_in_sel = '0; b_in_bcast = 1'b0; b_out_ready = 12'hFFF;
        test_reset();
        test_unicast_sweep();
        test_stall();
        test_bcast();
        test_bad_sel();
        test_async_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
